// File: rtl/route_sched.sv
// Route scheduler: queues station IDs received over UART, issues GO commands one leg at a time,
// waits for the robot to travel and dwell, and issues STOP on abort.
module route_sched #(
  parameter int DWELL_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] rx_byte,
  input  logic       rx_rdy,
  output logic       clr_rx_rdy,
  output logic [7:0] cmd,
  output logic       cmd_rdy,
  input  logic       clr_cmd_rdy,
  input  logic       in_transit,
  output logic       route_busy,
  output logic [2:0] q_cnt,
  output logic       overflow
);

  // Handshakes: rx_rdy is level-held by the UART and a byte is taken on the edge where
  // rx_rdy=1 and clr_rx_rdy=0; cmd_rdy is level-held here until clr_cmd_rdy is seen.
  typedef enum logic [2:0] {
    IDLE       = 3'd0,
    ISSUE      = 3'd1,
    WAIT_START = 3'd2,
    TRAVEL     = 3'd3,
    DWELL      = 3'd4,
    ABORT      = 3'd5
  } state_t;

  localparam logic [15:0] DWELL_LAST = 16'(DWELL_CYCLES - 1);

  state_t      state;
  logic [5:0]  mem [4];
  logic [1:0]  wr_ptr;
  logic [1:0]  rd_ptr;
  logic [2:0]  count;
  logic [15:0] dwell_cnt;

  logic take;
  logic is_enq;
  logic is_abort;
  logic pop;
  logic enq_ok;

  assign take     = rx_rdy && !clr_rx_rdy;
  assign is_enq   = take && (rx_byte[7:6] == 2'b01);
  assign is_abort = take && (rx_byte[7:6] == 2'b00);
  assign pop      = (state == ISSUE) && clr_cmd_rdy;
  // A pop on the same edge frees the slot, so a full queue can still accept.
  assign enq_ok   = is_enq && ((count != 3'd4) || pop);

  assign q_cnt      = count;
  assign route_busy = (state != IDLE);

  always_ff @(posedge clk) begin
    if (enq_ok) begin
      mem[wr_ptr] <= rx_byte[5:0];
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= 2'd0;
      rd_ptr     <= 2'd0;
      count      <= 3'd0;
      overflow   <= 1'b0;
      clr_rx_rdy <= 1'b0;
    end else begin
      clr_rx_rdy <= take;
      if (is_abort) begin
        wr_ptr   <= 2'd0;
        rd_ptr   <= 2'd0;
        count    <= 3'd0;
        overflow <= 1'b0;
      end else begin
        if (enq_ok) wr_ptr <= wr_ptr + 2'd1;
        if (pop)    rd_ptr <= rd_ptr + 2'd1;
        case ({enq_ok, pop})
          2'b10:   count <= count + 3'd1;
          2'b01:   count <= count - 3'd1;
          default: count <= count;
        endcase
        if (is_enq && !enq_ok) overflow <= 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      cmd       <= 8'h00;
      cmd_rdy   <= 1'b0;
      dwell_cnt <= 16'd0;
    end else begin
      case (state)
        IDLE: begin
          if (is_abort) begin
            // Only a moving robot needs an explicit STOP.
            if (in_transit) begin
              state   <= ABORT;
              cmd     <= 8'h00;
              cmd_rdy <= 1'b1;
            end
          end else if (count != 3'd0) begin
            state   <= ISSUE;
            cmd     <= {2'b01, mem[rd_ptr]};
            cmd_rdy <= 1'b1;
          end
        end
        ISSUE: begin
          if (is_abort) begin
            state   <= ABORT;
            cmd     <= 8'h00;
            cmd_rdy <= 1'b1;
          end else if (clr_cmd_rdy) begin
            state   <= WAIT_START;
            cmd_rdy <= 1'b0;
          end
        end
        WAIT_START: begin
          if (is_abort) begin
            state   <= ABORT;
            cmd     <= 8'h00;
            cmd_rdy <= 1'b1;
          end else if (in_transit) begin
            state <= TRAVEL;
          end
        end
        TRAVEL: begin
          if (is_abort) begin
            state   <= ABORT;
            cmd     <= 8'h00;
            cmd_rdy <= 1'b1;
          end else if (!in_transit) begin
            state     <= DWELL;
            dwell_cnt <= 16'd0;
          end
        end
        DWELL: begin
          if (is_abort) begin
            state   <= ABORT;
            cmd     <= 8'h00;
            cmd_rdy <= 1'b1;
          end else if (dwell_cnt == DWELL_LAST) begin
            state <= IDLE;
          end else begin
            dwell_cnt <= dwell_cnt + 16'd1;
          end
        end
        ABORT: begin
          if (is_abort) begin
            cmd     <= 8'h00;
            cmd_rdy <= 1'b1;
          end else if (clr_cmd_rdy) begin
            state   <= IDLE;
            cmd_rdy <= 1'b0;
          end
        end
        default: begin
          state   <= IDLE;
          cmd_rdy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_route_sched.sv
// Directed bench for route_sched with a short dwell; inputs change 1ns after the rising
// edge and outputs are read at the same point, well away from the next edge.
module tb_route_sched;

  localparam int DW = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic [7:0] rx_byte;
  logic       rx_rdy;
  logic       clr_rx_rdy;
  logic [7:0] cmd;
  logic       cmd_rdy;
  logic       clr_cmd_rdy;
  logic       in_transit;
  logic       route_busy;
  logic [2:0] q_cnt;
  logic       overflow;

  int errors = 0;
  int checks = 0;
  logic [7:0] exp_q[$];
  logic [7:0] e;

  always #5 clk = ~clk;

  route_sched #(.DWELL_CYCLES(DW)) dut (
    .clk(clk), .rst(rst), .rx_byte(rx_byte), .rx_rdy(rx_rdy), .clr_rx_rdy(clr_rx_rdy),
    .cmd(cmd), .cmd_rdy(cmd_rdy), .clr_cmd_rdy(clr_cmd_rdy), .in_transit(in_transit),
    .route_busy(route_busy), .q_cnt(q_cnt), .overflow(overflow)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b);
    rx_byte = b;
    rx_rdy  = 1'b1;
    tick();
    rx_rdy  = 1'b0;
  endtask

  // From ISSUE: consume the GO, travel, dwell, and land back in IDLE.
  task automatic finish_leg();
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    in_transit = 1'b1; tick();
    in_transit = 1'b0; tick();
    repeat (DW) tick();
  endtask

  task automatic test_reset();
    rst = 1'b1; rx_byte = 8'h00; rx_rdy = 1'b0; clr_cmd_rdy = 1'b0; in_transit = 1'b0;
    repeat (3) tick();
    rst = 1'b0;
    checks++; if (q_cnt !== 3'd0) begin errors++; $display("FAIL reset_q_cnt: got %0d want 0", q_cnt); end
    checks++; if (cmd !== 8'h00) begin errors++; $display("FAIL reset_cmd: got %h want 00", cmd); end
    checks++; if (cmd_rdy !== 1'b0) begin errors++; $display("FAIL reset_cmd_rdy: got %b want 0", cmd_rdy); end
    checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL reset_clr_rx: got %b want 0", clr_rx_rdy); end
    checks++; if (overflow !== 1'b0) begin errors++; $display("FAIL reset_overflow: got %b want 0", overflow); end
    checks++; if (route_busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", route_busy); end
  endtask

  task automatic test_basic();
    send_byte(8'h45);
    checks++; if (q_cnt !== 3'd1) begin errors++; $display("FAIL basic_q1: got %0d want 1", q_cnt); end
    checks++; if (clr_rx_rdy !== 1'b1) begin errors++; $display("FAIL basic_clr_pulse: got %b want 1", clr_rx_rdy); end
    checks++; if (route_busy !== 1'b0) begin errors++; $display("FAIL basic_idle: got %b want 0", route_busy); end
    tick();
    checks++; if (cmd_rdy !== 1'b1 || cmd !== 8'h45) begin errors++; $display("FAIL basic_issue: cmd=%h rdy=%b want 45/1", cmd, cmd_rdy); end
    checks++; if (clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL basic_clr_one_cycle: got %b want 0", clr_rx_rdy); end
    send_byte(8'h4A); tick();
    checks++; if (q_cnt !== 3'd2 || cmd !== 8'h45) begin errors++; $display("FAIL basic_q2: q=%0d cmd=%h want 2/45", q_cnt, cmd); end
    send_byte(8'h85);
    checks++; if (q_cnt !== 3'd2 || clr_rx_rdy !== 1'b1) begin errors++; $display("FAIL basic_ignore85: q=%0d clr=%b want 2/1", q_cnt, clr_rx_rdy); end
    tick();
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    checks++; if (q_cnt !== 3'd1 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL basic_pop: q=%0d rdy=%b want 1/0", q_cnt, cmd_rdy); end
    in_transit = 1'b1; tick(); tick();
    in_transit = 1'b0; tick();
    repeat (DW - 1) tick();
    checks++; if (route_busy !== 1'b1 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL basic_dwell_last: busy=%b rdy=%b want 1/0", route_busy, cmd_rdy); end
    tick();
    checks++; if (route_busy !== 1'b0) begin errors++; $display("FAIL basic_dwell_end: busy=%b want 0", route_busy); end
    tick();
    checks++; if (cmd_rdy !== 1'b1 || cmd !== 8'h4A) begin errors++; $display("FAIL basic_second: cmd=%h rdy=%b want 4a/1", cmd, cmd_rdy); end
    finish_leg();
    checks++; if (route_busy !== 1'b0 || q_cnt !== 3'd0) begin errors++; $display("FAIL basic_done: busy=%b q=%0d want 0/0", route_busy, q_cnt); end
  endtask

  task automatic test_overflow();
    send_byte(8'h41); tick(); send_byte(8'h42); tick();
    send_byte(8'h43); tick(); send_byte(8'h44); tick();
    checks++; if (q_cnt !== 3'd4 || overflow !== 1'b0) begin errors++; $display("FAIL ovf_full: q=%0d ovf=%b want 4/0", q_cnt, overflow); end
    send_byte(8'h45);
    checks++; if (q_cnt !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_drop: q=%0d ovf=%b want 4/1", q_cnt, overflow); end
    tick();
    exp_q = {8'h41, 8'h42, 8'h43, 8'h44};
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++; if (cmd_rdy !== 1'b1 || cmd !== e) begin errors++; $display("FAIL ovf_order%0d: cmd=%h rdy=%b want %h/1", i, cmd, cmd_rdy, e); end
      finish_leg();
      if (i < 3) tick();
    end
    checks++; if (q_cnt !== 3'd0 || route_busy !== 1'b0 || overflow !== 1'b1) begin errors++; $display("FAIL ovf_end: q=%0d busy=%b ovf=%b want 0/0/1", q_cnt, route_busy, overflow); end
  endtask

  task automatic test_abort_idle();
    send_byte(8'h00);
    checks++; if (overflow !== 1'b0 || cmd_rdy !== 1'b0 || route_busy !== 1'b0) begin errors++; $display("FAIL idle_abort: ovf=%b rdy=%b busy=%b want 0/0/0", overflow, cmd_rdy, route_busy); end
    tick();
    send_byte(8'hC5);
    checks++; if (clr_rx_rdy !== 1'b1 || q_cnt !== 3'd0) begin errors++; $display("FAIL idle_c5: clr=%b q=%0d want 1/0", clr_rx_rdy, q_cnt); end
    tick();
    checks++; if (cmd_rdy !== 1'b0 || route_busy !== 1'b0 || clr_rx_rdy !== 1'b0) begin errors++; $display("FAIL idle_c5_after: rdy=%b busy=%b clr=%b want 0/0/0", cmd_rdy, route_busy, clr_rx_rdy); end
    in_transit = 1'b1;
    send_byte(8'h00);
    checks++; if (route_busy !== 1'b1 || cmd_rdy !== 1'b1 || cmd !== 8'h00) begin errors++; $display("FAIL idle_abort_moving: busy=%b rdy=%b cmd=%h want 1/1/00", route_busy, cmd_rdy, cmd); end
    in_transit = 1'b0; tick();
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    checks++; if (route_busy !== 1'b0 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL idle_abort_done: busy=%b rdy=%b want 0/0", route_busy, cmd_rdy); end
  endtask

  task automatic test_abort_travel();
    send_byte(8'h51); tick(); send_byte(8'h52); tick();
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    in_transit = 1'b1; tick();
    send_byte(8'h53); tick();
    checks++; if (q_cnt !== 3'd2 || route_busy !== 1'b1 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL trv_enqueue: q=%0d busy=%b rdy=%b want 2/1/0", q_cnt, route_busy, cmd_rdy); end
    send_byte(8'h00);
    checks++; if (q_cnt !== 3'd0 || overflow !== 1'b0 || cmd !== 8'h00 || cmd_rdy !== 1'b1) begin errors++; $display("FAIL trv_abort: q=%0d ovf=%b cmd=%h rdy=%b want 0/0/00/1", q_cnt, overflow, cmd, cmd_rdy); end
    in_transit = 1'b0; tick(); tick();
    checks++; if (cmd_rdy !== 1'b1 || route_busy !== 1'b1) begin errors++; $display("FAIL trv_stop_held: rdy=%b busy=%b want 1/1", cmd_rdy, route_busy); end
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    checks++; if (cmd_rdy !== 1'b0 || route_busy !== 1'b0) begin errors++; $display("FAIL trv_idle: rdy=%b busy=%b want 0/0", cmd_rdy, route_busy); end
  endtask

  task automatic test_back_to_back();
    send_byte(8'h61); tick(); send_byte(8'h62); tick();
    send_byte(8'h63); tick(); send_byte(8'h64); tick();
    checks++; if (q_cnt !== 3'd4) begin errors++; $display("FAIL b2b_full: q=%0d want 4", q_cnt); end
    rx_byte = 8'h47; rx_rdy = 1'b1; clr_cmd_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    checks++; if (q_cnt !== 3'd4 || overflow !== 1'b0 || cmd_rdy !== 1'b0) begin errors++; $display("FAIL b2b_pop_enq: q=%0d ovf=%b rdy=%b want 4/0/0", q_cnt, overflow, cmd_rdy); end
    tick();
    in_transit = 1'b1; tick();
    in_transit = 1'b0; tick();
    repeat (DW) tick();
    tick();
    exp_q = {8'h62, 8'h63, 8'h64, 8'h47};
    for (int i = 0; i < 4; i++) begin
      e = exp_q.pop_front();
      checks++; if (cmd_rdy !== 1'b1 || cmd !== e) begin errors++; $display("FAIL b2b_order%0d: cmd=%h rdy=%b want %h/1", i, cmd, cmd_rdy, e); end
      finish_leg();
      if (i < 3) tick();
    end
    checks++; if (q_cnt !== 3'd0 || route_busy !== 1'b0) begin errors++; $display("FAIL b2b_end: q=%0d busy=%b want 0/0", q_cnt, route_busy); end
  endtask

  task automatic test_abort_with_clr();
    send_byte(8'h71); tick(); send_byte(8'h72); tick();
    rx_byte = 8'h00; rx_rdy = 1'b1; clr_cmd_rdy = 1'b1;
    tick();
    rx_rdy = 1'b0; clr_cmd_rdy = 1'b0;
    checks++; if (cmd !== 8'h00 || cmd_rdy !== 1'b1 || q_cnt !== 3'd0 || route_busy !== 1'b1) begin errors++; $display("FAIL aclr_stop: cmd=%h rdy=%b q=%0d busy=%b want 00/1/0/1", cmd, cmd_rdy, q_cnt, route_busy); end
    tick();
    checks++; if (cmd_rdy !== 1'b1) begin errors++; $display("FAIL aclr_held: rdy=%b want 1", cmd_rdy); end
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    checks++; if (cmd_rdy !== 1'b0 || route_busy !== 1'b0) begin errors++; $display("FAIL aclr_idle: rdy=%b busy=%b want 0/0", cmd_rdy, route_busy); end
  endtask

  task automatic test_reset_dwell();
    send_byte(8'h41); tick(); send_byte(8'h42); tick();
    send_byte(8'h43); tick(); send_byte(8'h44); tick();
    send_byte(8'h45); tick();
    checks++; if (q_cnt !== 3'd4 || overflow !== 1'b1) begin errors++; $display("FAIL rstd_setup: q=%0d ovf=%b want 4/1", q_cnt, overflow); end
    clr_cmd_rdy = 1'b1; tick(); clr_cmd_rdy = 1'b0;
    in_transit = 1'b1; tick();
    in_transit = 1'b0; tick(); tick();
    checks++; if (q_cnt !== 3'd3 || route_busy !== 1'b1) begin errors++; $display("FAIL rstd_in_dwell: q=%0d busy=%b want 3/1", q_cnt, route_busy); end
    rst = 1'b1; rx_byte = 8'h4F; rx_rdy = 1'b1;
    tick();
    rst = 1'b0; rx_rdy = 1'b0;
    checks++; if (q_cnt !== 3'd0 || overflow !== 1'b0 || cmd !== 8'h00) begin errors++; $display("FAIL rstd_state: q=%0d ovf=%b cmd=%h want 0/0/00", q_cnt, overflow, cmd); end
    checks++; if (cmd_rdy !== 1'b0 || clr_rx_rdy !== 1'b0 || route_busy !== 1'b0) begin errors++; $display("FAIL rstd_flags: rdy=%b clr=%b busy=%b want 0/0/0", cmd_rdy, clr_rx_rdy, route_busy); end
    repeat (DW + 2) tick();
    checks++; if (cmd_rdy !== 1'b0 || route_busy !== 1'b0 || q_cnt !== 3'd0) begin errors++; $display("FAIL rstd_no_stop: rdy=%b busy=%b q=%0d want 0/0/0", cmd_rdy, route_busy, q_cnt); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_basic();
    test_overflow();
    test_abort_idle();
    test_abort_travel();
    test_back_to_back();
    test_abort_with_clr();
    test_reset_dwell();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/route_sched.md
ROUTE_SCHED -- requirements
Module: route_sched

Interface
REQ-001 SHALL have parameter DWELL_CYCLES, default 1000, stop-dwell length in clk cycles (range 2..65535).
REQ-002 SHALL have port clk  input  1  the single clock, rising edge.
REQ-003 SHALL have port rst  input  1  reset, synchronous, active-high.
REQ-004 SHALL have port rx_byte  input  8  byte from UART receiver.
REQ-005 SHALL have port rx_rdy  input  1  rx_byte valid, held by UART until cleared.
REQ-006 SHALL have port clr_rx_rdy  output  1  one-cycle pulse consuming rx_byte.
REQ-007 SHALL have port cmd  output  8  command byte to command controller.
REQ-008 SHALL have port cmd_rdy  output  1  cmd valid, held until clr_cmd_rdy.
REQ-009 SHALL have port clr_cmd_rdy  input  1  command controller consumed cmd.
REQ-010 SHALL have port in_transit  input  1  robot travelling to a station.
REQ-011 SHALL have port route_busy  output  1  high in any state other than IDLE.
REQ-012 SHALL have port q_cnt  output  3  stations queued (0..4).
REQ-013 SHALL have port overflow  output  1  sticky, enqueue dropped on full queue.

Function
REQ-014 SHALL decode rx_byte[7:6]: 01 = enqueue station rx_byte[5:0]; 00 = abort; 10/11 = ignored but consumed.
REQ-015 SHALL process a byte on the edge where rx_rdy=1 and clr_rx_rdy=0, and drive clr_rx_rdy=1 for exactly the next cycle; rx_rdy SHALL be ignored while clr_rx_rdy=1.
REQ-016 SHALL hold a 4-entry circular FIFO of 6-bit station IDs: 2-bit wrapping read/write pointers, q_cnt = occupancy.
REQ-017 Enqueue with q_cnt=4 SHALL drop the byte, leave queue unchanged, set overflow=1.
REQ-018 Simultaneous enqueue and pop SHALL both occur, q_cnt unchanged; valid also at q_cnt=4 (pop frees the slot).
REQ-019 SHALL implement FSM states IDLE, ISSUE, WAIT_START, TRAVEL, DWELL, ABORT.
REQ-020 IDLE: q_cnt>0 -> ISSUE next edge; a station enqueued into an empty queue SHALL reach ISSUE the cycle after it is written.
REQ-021 ISSUE: cmd={2'b01, head ID}, cmd_rdy=1; on clr_cmd_rdy=1 SHALL pop head and go to WAIT_START; cmd_rdy low from the next cycle.
REQ-022 WAIT_START: in_transit=1 -> TRAVEL.
REQ-023 TRAVEL: in_transit=0 -> DWELL, dwell counter loaded to 0.
REQ-024 DWELL: counter increments each cycle; at DWELL_CYCLES-1 -> IDLE (DWELL lasts exactly DWELL_CYCLES cycles); 16-bit counter, no wrap.
REQ-025 Abort SHALL flush queue (pointers and q_cnt to 0), clear overflow, and on the same edge go to ABORT from any state except IDLE; in IDLE with in_transit=0 it SHALL only flush.
REQ-026 Abort in IDLE with in_transit=1 SHALL go to ABORT.
REQ-027 ABORT: cmd=8'h00, cmd_rdy=1 until clr_cmd_rdy=1, then IDLE.
REQ-028 Abort arriving on the same edge as clr_cmd_rdy in ISSUE: GO consumed (head popped then flushed), next state ABORT, STOP issued.
REQ-029 cmd SHALL be registered and stable whenever cmd_rdy=1; cmd_rdy SHALL never drop without clr_cmd_rdy except on reset.
REQ-030 Enqueue during WAIT_START/TRAVEL/DWELL SHALL be accepted without disturbing the current leg.

Reset
REQ-031 On rst=1 at a clk edge: state=IDLE, FIFO empty, q_cnt=0, cmd=8'h00, cmd_rdy=0, clr_rx_rdy=0, overflow=0, route_busy=0, dwell counter=0.
REQ-032 Reset mid-route SHALL abandon the leg without issuing STOP; rst SHALL dominate all other inputs.

Verification
REQ-033 Bytes 8'h45, 8'h4A -> q_cnt=2; cmd=8'h45 with cmd_rdy; clr_cmd_rdy -> q_cnt=1; in_transit 1 then 0 -> DWELL_CYCLES cycles later cmd=8'h4A, cmd_rdy=1.
REQ-034 Five enqueues (8'h41..8'h45) while in ISSUE with no clr_cmd_rdy -> q_cnt=4, overflow=1, 8'h45 dropped; issued order 01,02,03,04.
REQ-035 Byte 8'h00 during TRAVEL with q_cnt=2 -> q_cnt=0, overflow=0, cmd=8'h00, cmd_rdy=1 until clr_cmd_rdy, then IDLE, route_busy=0.
REQ-036 Byte 8'h00 in IDLE, in_transit=0 -> no cmd_rdy; 8'hC5 -> clr_rx_rdy pulse only, q_cnt unchanged.
REQ-037 Enqueue 8'h47 on the same edge as clr_cmd_rdy pop at q_cnt=4 -> q_cnt stays 4, overflow stays 0, 8'h47 at tail.
REQ-038 rst=1 during DWELL with q_cnt=3 -> next cycle all outputs at reset values, no STOP command issued.
